morse_seq_player: RTL and testbench

Parametrised successor of the fixed S/O buzzer sequencer. It plays a programmable sequence of up to MAX_SYM dot/dash symbols on one pin. Dot, dash and gap durations are set by parameters, based on a 1 ms tick derived from the system clock. The block sits between the top-level SOS/message controller and the buzzer pin, with a start/busy/done handshake and an abort input.

---
 rtl/morse_seq_player.sv | 189 ++++++++++++++++++
 tb/tb_morse_seq_player.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_seq_player.sv
// Purpose : plays a latched sequence of up to MAX_SYM dot/dash symbols on a single buzzer pin.
// Latency : tone starts on the accept edge; done pulses N*TICK_CYCLES+1 clocks after accept.
// Backpres: start is taken only in IDLE; requests while busy are dropped, abort wins over start.
module morse_seq_player #(
    parameter int   TICK_CYCLES = 50000,
    parameter int   MAX_SYM     = 8,
    parameter int   DOT_MS      = 100,
    parameter int   DASH_MS     = 400,
    parameter int   GAP_MS      = 50,
    parameter int   MS_W        = 10,
    parameter logic OUT_ACTIVE  = 1'b0,
    localparam int  CW          = $clog2(MAX_SYM) + 1
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start_sig,
    input  logic [CW-1:0]      sym_count,
    input  logic [MAX_SYM-1:0] sym_pattern,
    input  logic               abort_sig,
    output logic               busy_sig,
    output logic               done_sig,
    output logic               pin_out,
    output logic [CW-1:0]      sym_index
);

    // Prescaler is wide enough to hold TICK_CYCLES-1.
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [PW-1:0]      PRE_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [MS_W-1:0]    DOT_LAST  = MS_W'(DOT_MS - 1);
    localparam logic [MS_W-1:0]    DASH_LAST = MS_W'(DASH_MS - 1);
    localparam logic [MS_W-1:0]    GAP_LAST  = MS_W'(GAP_MS - 1);
    localparam logic [CW-1:0]      MAX_C     = CW'(MAX_SYM);
    localparam logic [CW-1:0]      ONE_C     = CW'(1);
    localparam logic [MAX_SYM-1:0] BIT0      = MAX_SYM'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TONE,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pre_q,   pre_d;
    logic [MS_W-1:0]    ms_q,    ms_d;
    logic [MAX_SYM-1:0] pat_q,   pat_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [CW-1:0]      idx_q,   idx_d;
    logic               pin_q,   pin_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               tick;
    logic               cur_dash;
    logic [MS_W-1:0]    phase_last;
    logic               phase_end;
    logic [CW-1:0]      cnt_in;

    // Phase timing: which symbol kind is playing, and whether the current phase ends this cycle.
    always_comb begin
        cur_dash   = |(pat_q & (BIT0 << idx_q));
        tick       = (pre_q == PRE_LAST);
        phase_last = GAP_LAST;
        if (state_q == S_TONE) begin
            phase_last = cur_dash ? DASH_LAST : DOT_LAST;
        end
        phase_end  = tick && (ms_q == phase_last);
        cnt_in     = (sym_count > MAX_C) ? MAX_C : sym_count;
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pin_d   = pin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (abort_sig && (state_q != S_IDLE)) begin
            // Abort drops everything without a completion pulse; sym_index is left as-is.
            state_d = S_IDLE;
            pre_d   = '0;
            ms_d    = '0;
            pin_d   = ~OUT_ACTIVE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_sig && !abort_sig) begin
                        pat_d  = sym_pattern;
                        cnt_d  = cnt_in;
                        idx_d  = '0;
                        busy_d = 1'b1;
                        pre_d  = '0;
                        ms_d   = '0;
                        if (cnt_in != '0) begin
                            state_d = S_TONE;
                            pin_d   = OUT_ACTIVE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end

                S_TONE: begin
                    if (phase_end) begin
                        state_d = S_GAP;
                        pin_d   = ~OUT_ACTIVE;
                        pre_d   = '0;
                        ms_d    = '0;
                    end else if (tick) begin
                        pre_d = '0;
                        ms_d  = ms_q + MS_W'(1);
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end

                S_GAP: begin
                    if (phase_end) begin
                        pre_d = '0;
                        ms_d  = '0;
                        if (idx_q == (cnt_q - ONE_C)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_TONE;
                            idx_d   = idx_q + ONE_C;
                            pin_d   = OUT_ACTIVE;
                        end
                    end else if (tick) begin
                        pre_d = '0;
                        ms_d  = ms_q + MS_W'(1);
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end

                S_DONE: begin
                    // The completion pulse and busy release land together on the exit edge.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end

                default: begin
                    state_d = S_IDLE;
                    pin_d   = ~OUT_ACTIVE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            pin_q   <= ~OUT_ACTIVE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pin_out   = pin_q;
    assign busy_sig  = busy_q;
    assign done_sig  = done_q;
    assign sym_index = idx_q;

endmodule

// File: tb/tb_morse_seq_player.sv
// Purpose : randomized and directed checks of morse_seq_player against a per-cycle expected waveform.
// Latency : expected trace starts at the accept edge and ends one idle cycle after done.
// Backpres: start/abort are driven on falling edges, outputs sampled on falling edges.
module tb_morse_seq_player;

    localparam int   T     = 4;
    localparam int   DOT   = 3;
    localparam int   DASH  = 6;
    localparam int   GAP   = 2;
    localparam int   MAXS  = 8;
    localparam int   CW    = $clog2(MAXS) + 1;
    localparam logic ACT   = 1'b0;
    localparam logic INACT = 1'b1;

    logic            clk;
    logic            rst_n;
    logic            start_sig;
    logic [CW-1:0]   sym_count;
    logic [MAXS-1:0] sym_pattern;
    logic            abort_sig;
    logic            busy_sig;
    logic            done_sig;
    logic            pin_out;
    logic [CW-1:0]   sym_index;
    logic [6:0]      obs;

    int n_vec;
    int n_err;

    assign obs = {pin_out, busy_sig, done_sig, sym_index};

    morse_seq_player #(
        .TICK_CYCLES(T),
        .MAX_SYM    (MAXS),
        .DOT_MS     (DOT),
        .DASH_MS    (DASH),
        .GAP_MS     (GAP),
        .MS_W       (10),
        .OUT_ACTIVE (ACT)
    ) dut (
        .CLK        (clk),
        .RSTn       (rst_n),
        .start_sig  (start_sig),
        .sym_count  (sym_count),
        .sym_pattern(sym_pattern),
        .abort_sig  (abort_sig),
        .busy_sig   (busy_sig),
        .done_sig   (done_sig),
        .pin_out    (pin_out),
        .sym_index  (sym_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got pin/busy/done/idx=%b expected %b", tag, got, exp);
        end
    endtask

    // One sequence: expected trace is the concatenation of per-symbol tone and gap windows,
    // one busy cycle after the last gap, the done cycle, then idle.
    task automatic play(input int c, input logic [MAXS-1:0] p, input int abort_at,
                        input int gap_start_at, input bit hold, input string name);
        logic [6:0] exp_q[$];
        int         cc;
        int         d;
        logic [3:0] last;
        cc = (c > MAXS) ? MAXS : c;
        for (int s = 0; s < cc; s++) begin
            d = p[s] ? DASH : DOT;
            for (int k = 0; k < d * T; k++)   exp_q.push_back({ACT,   1'b1, 1'b0, 4'(s)});
            for (int k = 0; k < GAP * T; k++) exp_q.push_back({INACT, 1'b1, 1'b0, 4'(s)});
        end
        last = (cc > 0) ? 4'(cc - 1) : 4'd0;
        exp_q.push_back({INACT, 1'b1, 1'b0, last});
        exp_q.push_back({INACT, 1'b0, 1'b1, last});
        exp_q.push_back({INACT, 1'b0, 1'b0, last});
        if (abort_at >= 0) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            exp_q.push_back({INACT, 1'b0, 1'b0, exp_q[abort_at][3:0]});
        end
        if (hold) begin
            void'(exp_q.pop_back());
            exp_q.push_back((cc > 0) ? {ACT, 1'b1, 1'b0, 4'd0} : {INACT, 1'b1, 1'b0, 4'd0});
        end

        start_sig   = 1'b1;
        sym_count   = CW'(c);
        sym_pattern = p;
        abort_sig   = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            check_eq($sformatf("%s j=%0d", name, j), obs, exp_q[j]);
            start_sig = hold ? 1'b1 : (j == gap_start_at);
            abort_sig = (j == abort_at);
            if (!hold) begin
                sym_count   = CW'($urandom);
                sym_pattern = MAXS'($urandom);
            end
        end
        start_sig = 1'b0;
        abort_sig = 1'b0;
        if (hold) begin
            abort_sig = 1'b1;
            @(negedge clk);
            check_eq({name, " abort-retrigger"}, obs, {INACT, 1'b0, 1'b0, 4'd0});
            abort_sig = 1'b0;
        end
    endtask

    initial begin
        int c;
        int cc;
        int ab;
        int gs;
        int d0;
        logic [MAXS-1:0] p;

        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        start_sig   = 1'b0;
        abort_sig   = 1'b0;
        sym_count   = '0;
        sym_pattern = '0;

        repeat (2) @(negedge clk);
        check_eq("reset-held", obs, {INACT, 1'b0, 1'b0, 4'd0});
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset-release", obs, {INACT, 1'b0, 1'b0, 4'd0});

        // S, O with a start pulse inside the first gap, mixed pattern with count clamp, count 0.
        play(3, 8'b0000_0000, -1, -1, 1'b0, "S");
        play(3, 8'b0000_0111, -1, 6 * T + 3, 1'b0, "O");
        play(9, 8'b1010_0101, -1, -1, 1'b0, "mixed-clamp");
        play(0, 8'b1111_1111, -1, -1, 1'b0, "count0");

        // Abort at the fifth clock of the second tone, then an immediate normal restart.
        play(3, 8'b0000_0000, (DOT + GAP) * T + 4, -1, 1'b0, "abort-tone2");
        play(3, 8'b0000_0010, -1, -1, 1'b0, "after-abort");

        // Abort arriving with start in IDLE keeps the block idle.
        start_sig = 1'b1;
        abort_sig = 1'b1;
        sym_count = CW'(2);
        @(negedge clk);
        check_eq("abort+start", {obs[6:4], 4'd0}, {INACT, 1'b0, 1'b0, 4'd0});
        start_sig = 1'b0;
        abort_sig = 1'b0;
        @(negedge clk);
        check_eq("abort+start-next", {obs[6:4], 4'd0}, {INACT, 1'b0, 1'b0, 4'd0});

        // Start held high re-triggers right after the done cycle.
        play(2, 8'b0000_0001, -1, -1, 1'b1, "hold");
        play(0, 8'b0000_0000, -1, -1, 1'b1, "hold0");

        // Reset pulsed mid-tone takes effect without waiting for a clock edge.
        start_sig   = 1'b1;
        sym_count   = CW'(3);
        sym_pattern = 8'b0000_0001;
        @(negedge clk);
        start_sig = 1'b0;
        check_eq("rst-pre", obs, {ACT, 1'b1, 1'b0, 4'd0});
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst-async", obs, {INACT, 1'b0, 1'b0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst-after", obs, {INACT, 1'b0, 1'b0, 4'd0});

        // Randomized sequences with occasional aborts and stray starts during a gap.
        for (int r = 0; r < 30; r++) begin
            c  = $urandom_range(0, 15);
            p  = MAXS'($urandom);
            cc = (c > MAXS) ? MAXS : c;
            ab = -1;
            gs = -1;
            if ($urandom_range(0, 3) == 0) begin
                int n_ms;
                n_ms = 0;
                for (int s = 0; s < cc; s++) n_ms += (p[s] ? DASH : DOT) + GAP;
                ab = $urandom_range(0, n_ms * T);
            end
            if (cc > 0 && $urandom_range(0, 1) == 1) begin
                d0 = p[0] ? DASH : DOT;
                gs = d0 * T + $urandom_range(0, GAP * T - 1);
            end
            play(c, p, ab, gs, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
